// File: rtl/ddr_arbiter.sv
// Two-port round-robin arbiter feeding the ddr_ctrl CPU-side line interface.
// Port 0 is the instruction cache and port 1 is the data cache. One 256-bit
// line transaction runs at a time. The grant is held until ddr_ctrl reports
// ready, or until a watchdog gives up on a hung transaction.
//
// state | meaning
// IDLE  | no owner; sample requests and grant one
// ISSUE | ram_en asserted; ram_rdy is stale and ignored for SETTLE cycles
// WAIT  | waiting for ram_rdy; the watchdog counts down
// DONE  | done pulse to the owner; release the grant
module ddr_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int LINE_W  = 256,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              req0_en,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LINE_W-1:0] req0_wdata,
  output logic              done0,
  input  logic              req1_en,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LINE_W-1:0] req1_wdata,
  output logic              done1,
  output logic [LINE_W-1:0] rdata,
  output logic              err,
  output logic [1:0]        grant,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] data_to_ram,
  input  logic              ram_rdy,
  input  logic [LINE_W-1:0] line_buf
);

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_winner;
  logic [1:0]        r_grant;
  logic              r_ram_en;
  logic              r_ram_write;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [LINE_W-1:0] r_data_to_ram;
  logic [LINE_W-1:0] r_rdata;
  logic              r_done0;
  logic              r_done1;
  logic              r_err;

  logic w_any_req;
  logic w_pick1;

  // Port 1 wins when it is alone, or when both are pending and port 0 won last time.
  assign w_any_req = req0_en | req1_en;
  assign w_pick1   = req1_en & (~req0_en | ~r_last_winner);

  // Sequencing FSM. A single down-counter times the settle window in ISSUE
  // and then serves as the watchdog in WAIT.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_winner <= 1'b1;
      r_grant       <= 2'b00;
      r_ram_en      <= 1'b0;
      r_ram_write   <= 1'b0;
      r_ram_addr    <= '0;
      r_data_to_ram <= '0;
      r_rdata       <= '0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant       <= w_pick1 ? 2'b10 : 2'b01;
            r_ram_addr    <= w_pick1 ? req1_addr  : req0_addr;
            r_ram_write   <= w_pick1 ? req1_write : req0_write;
            r_data_to_ram <= w_pick1 ? req1_wdata : req0_wdata;
            r_ram_en      <= 1'b1;
            r_cnt         <= SETTLE_LD;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_cnt   <= TIMEOUT_LD;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (ram_rdy) begin
            r_ram_en <= 1'b0;
            if (!r_ram_write) r_rdata <= line_buf;
            r_done0  <= r_grant[0];
            r_done1  <= r_grant[1];
            r_state  <= S_DONE;
          end else if (r_cnt == '0) begin
            // Abort: release ddr_ctrl and complete the owner with stale rdata.
            r_ram_en <= 1'b0;
            r_err    <= 1'b1;
            r_done0  <= r_grant[0];
            r_done1  <= r_grant[1];
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done0       <= 1'b0;
          r_done1       <= 1'b0;
          r_err         <= 1'b0;
          r_last_winner <= r_grant[1];
          r_grant       <= 2'b00;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done0       = r_done0;
  assign done1       = r_done1;
  assign err         = r_err;
  assign rdata       = r_rdata;
  assign grant       = r_grant;
  assign ram_en      = r_ram_en;
  assign ram_write   = r_ram_write;
  assign ram_addr    = r_ram_addr;
  assign data_to_ram = r_data_to_ram;

endmodule
